round_robin_tester: RTL and testbench

Dual-implementation round-robin queue arbiter harness for the queue-switch datapath. Two independently coded 4-queue round-robin arbiters are instantiated side by side. Both see identical clock, reset, enable and queue-empty inputs. Their grant outputs are exposed separately so a bench can check the behavioural arbiter ("plain" outputs) against the structurally coded arbiter ("sint_" outputs) cycle by cycle.

---
 rtl/round_robin_tester.sv | 139 +++++++++++++
 tb/tb_round_robin_tester.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/round_robin_tester.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | round_robin_tester: behavioural and structural 4-queue RR arbiters       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module rr_arb_behav (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_enb,
  input  logic [3:0] i_empty,
  output logic [1:0] o_sel,
  output logic       o_vld
);
  logic [1:0] r_ptr;
  logic [1:0] r_sel;
  logic       r_vld;
  logic [1:0] w_next;
  logic [1:0] w_idx;
  logic       w_any;

  // Walk candidates farthest-first so the nearest non-empty queue wins last.
  always_comb begin
    w_next = r_ptr;
    w_idx  = r_ptr;
    w_any  = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      w_idx = r_ptr + 2'(k);
      if (!i_empty[w_idx]) begin
        w_next = w_idx;
        w_any  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= 2'd3;
      r_sel <= 2'd0;
      r_vld <= 1'b0;
    end else if (i_enb && w_any) begin
      r_ptr <= w_next;
      r_sel <= w_next;
      r_vld <= 1'b1;
    end else begin
      r_vld <= 1'b0;
    end
  end

  assign o_sel = r_sel;
  assign o_vld = r_vld;
endmodule

module rr_arb_struct (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_enb,
  input  logic [3:0] i_empty,
  output logic [1:0] o_sel,
  output logic       o_vld
);
  logic [3:0] r_last;
  logic [1:0] r_sel;
  logic       r_vld;
  logic [3:0] w_req;
  logic [3:0] w_above;
  logic [3:0] w_req_hi;
  logic [3:0] w_pool;
  logic [3:0] w_grant;
  logic [1:0] w_enc;
  logic       w_fire;

  assign w_req    = ~i_empty;
  // Mask of queues strictly after the one-hot last grant; empty when last is queue 3.
  assign w_above  = ~({r_last[2:0], 1'b0} - 4'd1);
  assign w_req_hi = w_req & w_above;
  assign w_pool   = (|w_req_hi) ? w_req_hi : w_req;
  assign w_grant  = w_pool & (~w_pool + 4'd1);
  assign w_enc    = {w_grant[3] | w_grant[2], w_grant[3] | w_grant[1]};
  assign w_fire   = i_enb & (|w_req);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= 4'b1000;
      r_sel  <= 2'd0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= w_fire;
      if (w_fire) begin
        r_last <= w_grant;
        r_sel  <= w_enc;
      end
    end
  end

  assign o_sel = r_sel;
  assign o_vld = r_vld;
endmodule

module round_robin_tester #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enb,
  input  logic [QUEUE_QUANTITY-1:0] buf_empty,
  output logic [1:0]                selector,
  output logic                      out_enb,
  output logic [1:0]                sint_selector,
  output logic                      sint_out_enb
);
  // Only the 4-queue configuration is built; anything else yields idle outputs.
  if (QUEUE_QUANTITY == 4 && DATA_BITS > 0) begin : g_arb
    rr_arb_behav u_arb_a (
      .clk     (clk),
      .rst     (rst),
      .i_enb   (enb),
      .i_empty (buf_empty),
      .o_sel   (selector),
      .o_vld   (out_enb)
    );

    rr_arb_struct u_arb_b (
      .clk     (clk),
      .rst     (rst),
      .i_enb   (enb),
      .i_empty (buf_empty),
      .o_sel   (sint_selector),
      .o_vld   (sint_out_enb)
    );
  end else begin : g_unsupported
    assign selector      = 2'd0;
    assign out_enb       = 1'b0;
    assign sint_selector = 2'd0;
    assign sint_out_enb  = 1'b0;
  end
endmodule
`default_nettype wire

// File: tb/tb_round_robin_tester.sv
`default_nettype none
// Bench for round_robin_tester: directed plan plus random traffic against a queue-order model.
module tb_round_robin_tester;
  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic [3:0] buf_empty;
  logic [1:0] selector;
  logic       out_enb;
  logic [1:0] sint_selector;
  logic       sint_out_enb;

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr;
  int m_sel;
  int m_vld;

  always #5 clk = ~clk;

  round_robin_tester #(
    .QUEUE_QUANTITY (4),
    .DATA_BITS      (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enb           (enb),
    .buf_empty     (buf_empty),
    .selector      (selector),
    .out_enb       (out_enb),
    .sint_selector (sint_selector),
    .sint_out_enb  (sint_out_enb)
  );

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 3;
    m_sel = 0;
    m_vld = 0;
  endtask

  task automatic check_all(input string tag);
    chk_eq({tag, "_sel"},      int'(selector),      m_sel);
    chk_eq({tag, "_vld"},      int'(out_enb),       m_vld);
    chk_eq({tag, "_sint_sel"}, int'(sint_selector), m_sel);
    chk_eq({tag, "_sint_vld"}, int'(sint_out_enb),  m_vld);
  endtask

  // One clock edge: model the grant from the inputs held at the edge, then compare.
  task automatic step(input string tag);
    bit found;
    int idx;
    @(posedge clk);
    if (rst) begin
      found = 1'b0;
      if (enb) begin
        for (int k = 1; k <= 4; k++) begin
          idx = (m_ptr + k) % 4;
          if (!found && !buf_empty[idx]) begin
            found = 1'b1;
            m_sel = idx;
            m_ptr = idx;
          end
        end
      end
      m_vld = found ? 1 : 0;
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic e, input logic [3:0] be);
    @(negedge clk);
    enb       = e;
    buf_empty = be;
  endtask

  initial begin
    rst       = 1'b0;
    enb       = 1'b0;
    buf_empty = 4'hF;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b1;
    enb       = 1'b1;
    buf_empty = 4'b0000;

    for (int i = 0; i < 5; i++) begin
      step("rot");
      chk_eq("rot_expect", int'(selector), i % 4);
    end

    drive(1'b1, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      step("skip0");
      chk_eq("skip0_expect", int'(selector), (i % 3) + 1);
    end
    drive(1'b1, 4'b0000);
    step("unskip");
    chk_eq("unskip_expect", int'(selector), 0);

    drive(1'b1, 4'b1111);
    step("allempty");
    chk_eq("allempty_vld", int'(out_enb), 0);
    chk_eq("allempty_hold", int'(selector), 0);
    drive(1'b1, 4'b1011);
    step("only2");
    chk_eq("only2_expect", int'(selector), 2);

    drive(1'b1, 4'b1101);
    for (int i = 0; i < 4; i++) begin
      step("only1");
      chk_eq("only1_expect", int'(selector), 1);
    end

    drive(1'b1, 4'b0000);
    step("to2");
    chk_eq("to2_expect", int'(selector), 2);
    drive(1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step("disabled");
      chk_eq("disabled_sel", int'(selector), 2);
    end
    drive(1'b1, 4'b0000);
    step("reenable");
    chk_eq("reenable_expect", int'(selector), 3);

    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    step("in_rst");
    @(negedge clk);
    rst = 1'b1;
    step("post_rst");
    chk_eq("post_rst_expect", int'(selector), 0);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      enb       = ($urandom_range(0, 9) != 0);
      buf_empty = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("rnd_rst");
        @(negedge clk);
        rst = 1'b1;
      end
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
